// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_pkg
//  Description : Shared encodings, FSM state type and alignment helper for the
//                MIPS memory stage.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

    // Lane-handling datapath is fixed at 32 bits
    localparam int DATA_W = 32;

    // MemSize encodings; 2'b11 is reserved and behaves as a word access
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Halfwords need an even address, words (and reserved size) a 4-byte one
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic w_bad;
        case (size)
            SZ_BYTE: w_bad = 1'b0;
            SZ_HALF: w_bad = offset[0];
            default: w_bad = (offset != 2'b00);
        endcase
        return w_bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_align
//  Description : Combinational lane handling for the memory stage. Store side
//                replicates store data across lanes and builds byte enables;
//                load side extracts the addressed lane(s) and extends them.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_off,
    input  logic [DATA_W-1:0] st_data,
    output logic [3:0]        st_be,
    output logic [DATA_W-1:0] st_wdata,
    input  logic [1:0]        ld_size,
    input  logic [1:0]        ld_off,
    input  logic              ld_sign,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store lanes: replicate the low bits so any enabled lane carries the data
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Load lanes: little-endian extraction followed by sign/zero extension
    always_comb begin
        w_byte  = ld_rdata[7:0];
        w_half  = ld_rdata[15:0];
        ld_data = ld_rdata;
        case (ld_off)
            2'd0:    w_byte = ld_rdata[7:0];
            2'd1:    w_byte = ld_rdata[15:8];
            2'd2:    w_byte = ld_rdata[23:16];
            default: w_byte = ld_rdata[31:24];
        endcase
        w_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_sign & w_byte[7]}}, w_byte};
            SZ_HALF: ld_data = {{16{ld_sign & w_half[15]}}, w_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MIPS memory stage. Issues byte/half/word loads and stores to
//                a data RAM over a req/ready handshake, stalls upstream while
//                an access is outstanding and registers the MEM/WB boundary.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage
    import mips_mem_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              MemSign,
    input  logic [WIDTH-1:0]  ALUOut,
    input  logic [WIDTH-1:0]  Reg2,
    input  logic              RegWrite_in,
    input  logic [4:0]        WriteReg_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ready,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [WIDTH-1:0]  ReadData,
    output logic [WIDTH-1:0]  ALUResult,
    output logic              RegWrite,
    output logic [4:0]        WriteReg,
    output logic              addr_err
);

    state_t r_state;
    state_t w_state_nxt;

    logic              w_access;
    logic              w_misaligned;
    logic              w_start;
    logic [3:0]        w_st_be;
    logic [WIDTH-1:0]  w_st_wdata;
    logic [WIDTH-1:0]  w_ld_data;

    // Fields of the in-flight access, held until the memory completes it
    logic [1:0]        r_size;
    logic [1:0]        r_off;
    logic              r_sign;
    logic [WIDTH-1:0]  r_alu;
    logic              r_rw;
    logic [4:0]        r_wr;

    // A simultaneous read+write is a store, so either flag starts an access
    assign w_access     = MemRead | MemWrite;
    assign w_misaligned = is_misaligned(MemSize, ALUOut[1:0]);
    assign w_start      = (r_state == IDLE) && w_access && !w_misaligned;

    mem_align u_align (
        .st_size  (MemSize),
        .st_off   (ALUOut[1:0]),
        .st_data  (Reg2),
        .st_be    (w_st_be),
        .st_wdata (w_st_wdata),
        .ld_size  (r_size),
        .ld_off   (r_off),
        .ld_sign  (r_sign),
        .ld_rdata (mem_rdata),
        .ld_data  (w_ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and stall: upstream holds from request launch until ready
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = ACCESS;
                    stall       = 1'b1;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory request, pending-access fields and MEM/WB boundary registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            ReadData  <= '0;
            ALUResult <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            addr_err  <= 1'b0;
            r_size    <= '0;
            r_off     <= '0;
            r_sign    <= 1'b0;
            r_alu     <= '0;
            r_rw      <= 1'b0;
            r_wr      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= ALUOut[WIDTH-1:2];
                        mem_be    <= w_st_be;
                        mem_wdata <= w_st_wdata;
                        r_size    <= MemSize;
                        r_off     <= ALUOut[1:0];
                        r_sign    <= MemSign;
                        r_alu     <= ALUOut;
                        r_rw      <= RegWrite_in;
                        r_wr      <= WriteReg_in;
                        // Bubble into writeback while the access is in flight
                        RegWrite  <= 1'b0;
                        addr_err  <= 1'b0;
                    end else begin
                        // Pass-through op, or a misaligned access that is dropped
                        ALUResult <= ALUOut;
                        RegWrite  <= RegWrite_in & ~w_access;
                        WriteReg  <= WriteReg_in;
                        ReadData  <= '0;
                        addr_err  <= w_access;
                    end
                end
                ACCESS: begin
                    addr_err <= 1'b0;
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        ALUResult <= r_alu;
                        RegWrite  <= r_rw & ~mem_we;
                        WriteReg  <= r_wr;
                        ReadData  <= mem_we ? '0 : w_ld_data;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
